dp_acc_drain: RTL and testbench

- Sits directly downstream of the dot-product group.
- Accumulates its N_UNIT signed lane results over a programmed number of K-steps into per-lane accumulators.
- Then drains the final sums one lane per beat over a valid/ready stream toward the output writeback.
- Decouples the array's fixed-rate production from a back-pressured consumer.

---
 rtl/dp_acc_drain.sv | 102 ++++++++++
 tb/tb_dp_acc_drain.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_acc_drain.sv
// Per-lane accumulator behind the dot-product group: sums k_len input beats
// per lane, then drains one lane per handshake over a valid/ready stream.
module dp_acc_drain #(
    parameter int N_UNIT = 4,
    parameter int DW_ADD = 32,
    parameter int CW     = 8,
    parameter int IW     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CW-1:0]            k_len,
    input  logic                     in_valid,
    input  logic [N_UNIT*DW_ADD-1:0] in_psum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DW_ADD-1:0] out_data,
    output logic [IW-1:0]            out_idx,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [DW_ADD-1:0] acc_q [N_UNIT];
    logic signed [DW_ADD-1:0] acc_d [N_UNIT];
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            klen_q, klen_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            for (int i = 0; i < N_UNIT; i++) acc_q[i] <= '0;
            cnt_q   <= '0;
            klen_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            klen_q  <= klen_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        klen_d  = klen_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero-length tile has nothing to drain, so it never leaves IDLE.
                if (start && (k_len != '0)) begin
                    klen_d = k_len;
                    cnt_d  = '0;
                    for (int i = 0; i < N_UNIT; i++) acc_d[i] = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    for (int i = 0; i < N_UNIT; i++)
                        acc_d[i] = acc_q[i] + signed'(in_psum[DW_ADD*i +: DW_ADD]);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == klen_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_q == IW'(N_UNIT - 1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset drops them at once.
    assign out_valid = (state_q == DRAIN);
    assign out_data  = acc_q[idx_q];
    assign out_idx   = idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_dp_acc_drain.sv
// Scoreboard bench for dp_acc_drain: random tiles against a per-lane sum model.
module tb_dp_acc_drain;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [CW-1:0]        k_len;
    logic                 in_valid;
    logic [N*DW-1:0]      in_psum;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic [IW-1:0]        out_idx;
    logic                 busy;
    logic                 done;

    dp_acc_drain #(.N_UNIT(N), .DW_ADD(DW), .CW(CW), .IW(IW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_psum  (in_psum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0]        idx;
        logic signed [DW-1:0] data;
    } exp_t;

    exp_t            sb[$];
    logic [N*DW-1:0] beats[$];
    int              checks   = 0;
    int              errors   = 0;
    int              done_cnt = 0;
    int              exp_done = 0;
    int              rdy_mode = 0;
    logic            prev_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] pack4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] c, input logic [DW-1:0] d);
        return {d, c, b, a};
    endfunction

    // out_ready: 0 = always high, 1 = random, 2 = repeating 1,0,0
    initial begin
        int n = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (n % 3 == 0);
                default: out_ready = 1'b1;
            endcase
            n++;
        end
    end

    // Monitor: every presented beat must match the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                done_cnt++;
                chk("done_single", 64'(prev_done), 64'd0);
                chk("busy_at_done", 64'(busy), 64'd0);
                chk("valid_at_done", 64'(out_valid), 64'd0);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("beat_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    chk("out_idx", 64'(out_idx), 64'(sb[0].idx));
                    chk("out_data", 64'(out_data), 64'(sb[0].data));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
        prev_done = done;
    end

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_psum  = {N{$urandom}};
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = 0;
        while (!done && dc < 400) begin
            in_valid = 1'($urandom_range(0, 1));
            in_psum  = {N{$urandom}};
            tick();
            dc++;
        end
        in_valid = 1'b0;
        chk("done_seen", 64'(done), 64'd1);
        if (done) exp_done++;
    endtask

    // Runs one tile using the beats queue; k_len is the number of beats.
    task automatic run_tile(input int gap, input bit poke, input bit nowait, output int dc);
        logic signed [DW-1:0] s;
        exp_t                 e;
        int                   ng;
        for (int i = 0; i < N; i++) begin
            s = '0;
            foreach (beats[b]) s = s + beats[b][DW*i +: DW];
            e.idx  = IW'(i);
            e.data = s;
            sb.push_back(e);
        end
        in_valid = 1'b0;
        start    = 1'b1;
        k_len    = CW'(beats.size());
        tick();
        start = 1'b0;
        k_len = 8'($urandom);
        chk("busy_after_start", 64'(busy), 64'd1);
        foreach (beats[b]) begin
            ng = (gap < 0) ? int'($urandom_range(0, 2)) : ((b == 0) ? 0 : gap);
            for (int g = 0; g < ng; g++) begin
                if (poke && b == 1 && g == 0) begin
                    start = 1'b1;
                    k_len = 8'd5;
                end
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_psum  = beats[b];
            tick();
            in_valid = 1'b0;
        end
        chk("first_valid_latency", 64'(out_valid), 64'd1);
        dc = 0;
        if (!nowait) wait_done(dc);
    endtask

    initial begin
        int dc;
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int dc;
        reset = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; in_psum = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        idle_cycles(2);

        // Basic tile: 6,17,28,39 on consecutive cycles
        rdy_mode = 0;
        beats = {};
        beats.push_back(pack4(1, 2, 3, 4));
        beats.push_back(pack4(10, 20, 30, 40));
        beats.push_back(pack4(-5, -5, -5, -5));
        run_tile(0, 1'b0, 1'b0, dc);
        chk("drain_cycles", 64'(dc), 64'(N));
        chk("busy_fall_with_done", 64'(busy), 64'd0);
        idle_cycles(3);

        // Gaps, back-pressure, and an ignored start(k_len=5) mid-ACC
        rdy_mode = 2;
        beats = {};
        beats.push_back(pack4(7, 7, 7, 7));
        beats.push_back(pack4(-7, -7, -7, -7));
        run_tile(3, 1'b1, 1'b0, dc);
        idle_cycles(2);

        // Zero-length start is ignored
        start = 1'b1; k_len = '0;
        tick();
        start = 1'b0;
        chk("zero_k_busy", 64'(busy), 64'd0);
        tick();
        chk("zero_k_busy2", 64'(busy), 64'd0);

        // Overflow wrap on lane 0
        rdy_mode = 1;
        beats = {};
        beats.push_back(pack4(32'h7FFF_FFFF, $urandom, $urandom, $urandom));
        beats.push_back(pack4(32'd1, $urandom, $urandom, $urandom));
        run_tile(-1, 1'b0, 1'b0, dc);
        idle_cycles(2);

        // Reset asserted while draining lane 2
        rdy_mode = 0;
        beats = {};
        beats.push_back(pack4($urandom, $urandom, $urandom, $urandom));
        beats.push_back(pack4($urandom, $urandom, $urandom, $urandom));
        run_tile(0, 1'b0, 1'b1, dc);
        tick();
        tick();
        chk("pre_rst_idx", 64'(out_idx), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_idx", 64'(out_idx), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        beats = {};
        beats.push_back(pack4(9, 9, 9, 9));
        run_tile(0, 1'b0, 1'b0, dc);

        // Back-to-back: start in the done cycle, then random tiles
        beats = {};
        beats.push_back(pack4($urandom, $urandom, $urandom, $urandom));
        run_tile(0, 1'b0, 1'b0, dc);
        rdy_mode = 1;
        for (int t = 0; t < 20; t++) begin
            int k;
            k = int'($urandom_range(1, 6));
            beats = {};
            for (int b = 0; b < k; b++)
                beats.push_back(pack4($urandom, $urandom, $urandom, $urandom));
            run_tile(-1, 1'($urandom_range(0, 1)), 1'b0, dc);
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(3);

        chk("done_count", 64'(done_cnt), 64'(exp_done));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
